// File: rtl/audio_dac_serializer.sv
// Transmit-side codec serial port: buffers left/right samples in per-channel
// FIFOs and shifts them onto DACDAT against the codec-mastered BCLK/DACLRCK.
module audio_dac_serializer #(
  parameter int unsigned DATA_WIDTH = 24,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned LJ_MODE    = 0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  bclk,
  input  logic                  daclrck,
  output logic                  dacdat,
  input  logic [DATA_WIDTH-1:0] left_data,
  input  logic                  left_valid,
  output logic                  left_ready,
  input  logic [DATA_WIDTH-1:0] right_data,
  input  logic                  right_valid,
  output logic                  right_ready,
  input  logic                  mute,
  output logic                  underrun_left,
  output logic                  underrun_right
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned BIT_W = $clog2(DATA_WIDTH + 1);

  typedef enum logic [1:0] {IDLE, DELAY, SHIFT, PAD} state_t;

  // Synchronizer chains: [1] is the synchronized level, [2] its previous value
  logic [2:0] bclk_sync;
  logic [2:0] lr_sync;

  logic [DATA_WIDTH-1:0] mem_l [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_l_q, rd_l_q, wr_r_q, rd_r_q;
  logic [CNT_W-1:0]      cnt_l_q, cnt_r_q;

  state_t                state_q;
  logic [DATA_WIDTH-1:0] shreg_q;
  logic [BIT_W-1:0]      bit_cnt_q;

  logic                  bclk_fall_c, lr_edge_c, lr_now_c;
  logic                  start_l_c, start_r_c;
  logic                  empty_l_c, empty_r_c;
  logic                  push_l_c, push_r_c, pop_l_c, pop_r_c;
  logic [CNT_W-1:0]      cnt_l_next_c, cnt_r_next_c;
  logic [DATA_WIDTH-1:0] load_c;

  // Bring codec clocks into the clk domain
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bclk_sync <= '0;
      lr_sync   <= '0;
    end else begin
      bclk_sync <= {bclk_sync[1:0], bclk};
      lr_sync   <= {lr_sync[1:0], daclrck};
    end
  end

  // Edge detection, FIFO handshakes and the value loaded at frame start
  always_comb begin
    bclk_fall_c  = bclk_sync[2] & ~bclk_sync[1];
    lr_edge_c    = lr_sync[2] ^ lr_sync[1];
    lr_now_c     = lr_sync[1];
    start_l_c    = lr_edge_c & ~lr_now_c;
    start_r_c    = lr_edge_c & lr_now_c;
    empty_l_c    = (cnt_l_q == '0);
    empty_r_c    = (cnt_r_q == '0);
    push_l_c     = left_valid & left_ready;
    push_r_c     = right_valid & right_ready;
    pop_l_c      = start_l_c & ~empty_l_c;
    pop_r_c      = start_r_c & ~empty_r_c;
    cnt_l_next_c = cnt_l_q + CNT_W'(push_l_c) - CNT_W'(pop_l_c);
    cnt_r_next_c = cnt_r_q + CNT_W'(push_r_c) - CNT_W'(pop_r_c);
    load_c       = '0;
    if (!mute) begin
      if (lr_now_c && !empty_r_c) begin
        load_c = mem_r[rd_r_q];
      end else if (!lr_now_c && !empty_l_c) begin
        load_c = mem_l[rd_l_q];
      end
    end
  end

  // Sample storage; contents need no reset since counts gate every read
  always_ff @(posedge clk) begin
    if (push_l_c) mem_l[wr_l_q] <= left_data;
    if (push_r_c) mem_r[wr_r_q] <= right_data;
  end

  // FIFO pointers/counts, registered readys and underrun pulses
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_l_q         <= '0;
      rd_l_q         <= '0;
      cnt_l_q        <= '0;
      wr_r_q         <= '0;
      rd_r_q         <= '0;
      cnt_r_q        <= '0;
      left_ready     <= 1'b0;
      right_ready    <= 1'b0;
      underrun_left  <= 1'b0;
      underrun_right <= 1'b0;
    end else begin
      if (push_l_c) wr_l_q <= wr_l_q + PTR_W'(1);
      if (pop_l_c)  rd_l_q <= rd_l_q + PTR_W'(1);
      if (push_r_c) wr_r_q <= wr_r_q + PTR_W'(1);
      if (pop_r_c)  rd_r_q <= rd_r_q + PTR_W'(1);
      cnt_l_q        <= cnt_l_next_c;
      cnt_r_q        <= cnt_r_next_c;
      left_ready     <= (cnt_l_next_c != CNT_W'(FIFO_DEPTH));
      right_ready    <= (cnt_r_next_c != CNT_W'(FIFO_DEPTH));
      underrun_left  <= start_l_c & empty_l_c;
      underrun_right <= start_r_c & empty_r_c;
    end
  end

  // Frame sequencer: a word-clock edge always restarts the slot, BCLK falls advance it
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      dacdat    <= 1'b0;
    end else if (lr_edge_c) begin
      if (LJ_MODE != 0) begin
        dacdat    <= load_c[DATA_WIDTH-1];
        shreg_q   <= load_c << 1;
        bit_cnt_q <= BIT_W'(1);
        state_q   <= SHIFT;
      end else begin
        dacdat    <= 1'b0;
        shreg_q   <= load_c;
        bit_cnt_q <= '0;
        state_q   <= DELAY;
      end
    end else if (bclk_fall_c) begin
      case (state_q)
        DELAY: begin
          dacdat    <= shreg_q[DATA_WIDTH-1];
          shreg_q   <= shreg_q << 1;
          bit_cnt_q <= BIT_W'(1);
          state_q   <= SHIFT;
        end
        SHIFT: begin
          if (bit_cnt_q == BIT_W'(DATA_WIDTH)) begin
            dacdat  <= 1'b0;
            state_q <= PAD;
          end else begin
            dacdat    <= shreg_q[DATA_WIDTH-1];
            shreg_q   <= shreg_q << 1;
            bit_cnt_q <= bit_cnt_q + BIT_W'(1);
          end
        end
        PAD: begin
          dacdat <= 1'b0;
        end
        default: begin
          dacdat <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_audio_dac_serializer.sv
// Self-checking bench: an I2S and a left-justified instance share one stimulus
// stream and are compared bit-by-bit against a queue-based slot model.
module tb_audio_dac_serializer;

  localparam int DW        = 24;
  localparam int DEPTH     = 4;
  localparam int HALF_BCLK = 160;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          bclk = 1'b0;
  logic          daclrck = 1'b0;
  logic          mute = 1'b0;
  logic [DW-1:0] left_data = '0;
  logic [DW-1:0] right_data = '0;
  logic          left_valid = 1'b0;
  logic          right_valid = 1'b0;

  logic dacdat_i2s, left_ready_i2s, right_ready_i2s, underrun_left_i2s, underrun_right_i2s;
  logic dacdat_lj, left_ready_lj, right_ready_lj, underrun_left_lj, underrun_right_lj;

  int errors = 0;
  int checks = 0;
  int ur_l_i2s = 0;
  int ur_r_i2s = 0;
  int ur_l_lj = 0;
  int ur_r_lj = 0;

  logic [DW-1:0] q_l[$];
  logic [DW-1:0] q_r[$];

  audio_dac_serializer #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .LJ_MODE(0)) u_i2s (
    .clk(clk), .reset_n(reset_n), .bclk(bclk), .daclrck(daclrck), .dacdat(dacdat_i2s),
    .left_data(left_data), .left_valid(left_valid), .left_ready(left_ready_i2s),
    .right_data(right_data), .right_valid(right_valid), .right_ready(right_ready_i2s),
    .mute(mute), .underrun_left(underrun_left_i2s), .underrun_right(underrun_right_i2s)
  );

  audio_dac_serializer #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .LJ_MODE(1)) u_lj (
    .clk(clk), .reset_n(reset_n), .bclk(bclk), .daclrck(daclrck), .dacdat(dacdat_lj),
    .left_data(left_data), .left_valid(left_valid), .left_ready(left_ready_lj),
    .right_data(right_data), .right_valid(right_valid), .right_ready(right_ready_lj),
    .mute(mute), .underrun_left(underrun_left_lj), .underrun_right(underrun_right_lj)
  );

  always #10 clk = ~clk;

  // Count clk cycles each underrun output is high
  always @(negedge clk) begin
    if (underrun_left_i2s)  ur_l_i2s <= ur_l_i2s + 1;
    if (underrun_right_i2s) ur_r_i2s <= ur_r_i2s + 1;
    if (underrun_left_lj)   ur_l_lj  <= ur_l_lj + 1;
    if (underrun_right_lj)  ur_r_lj  <= ur_r_lj + 1;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Expected DACDAT at the k-th rising BCLK of a slot carrying sample v
  function automatic logic exp_bit(input bit lj, input logic [DW-1:0] v, input int k);
    int pos;
    pos = lj ? k : k - 1;
    if (pos >= 0 && pos < DW) return v[DW-1-pos];
    return 1'b0;
  endfunction

  task automatic check_readys(input string tag);
    check({tag, " left_ready_i2s"},  left_ready_i2s,  q_l.size() < DEPTH);
    check({tag, " right_ready_i2s"}, right_ready_i2s, q_r.size() < DEPTH);
    check({tag, " left_ready_lj"},   left_ready_lj,   q_l.size() < DEPTH);
    check({tag, " right_ready_lj"},  right_ready_lj,  q_r.size() < DEPTH);
  endtask

  task automatic push(input bit ch, input logic [DW-1:0] d);
    @(negedge clk);
    check_readys("push");
    if (!ch && q_l.size() < DEPTH) begin
      left_data = d;
      left_valid = 1'b1;
      @(negedge clk);
      left_valid = 1'b0;
      q_l.push_back(d);
    end else if (ch && q_r.size() < DEPTH) begin
      right_data = d;
      right_valid = 1'b1;
      @(negedge clk);
      right_valid = 1'b0;
      q_r.push_back(d);
    end
  endtask

  // One codec half-frame of nbits BCLKs; daclrck takes value lr on the first fall
  task automatic frame(input bit lr, input int nbits, input bit edge_exp);
    logic [DW-1:0] v;
    bit uf;
    int l0, r0, l1, r1;
    v = '0;
    uf = 1'b0;
    if (edge_exp) begin
      if (lr) begin
        if (q_r.size() == 0) uf = 1'b1;
        else v = q_r.pop_front();
      end else begin
        if (q_l.size() == 0) uf = 1'b1;
        else v = q_l.pop_front();
      end
      if (mute) v = '0;
    end
    l0 = ur_l_i2s; r0 = ur_r_i2s; l1 = ur_l_lj; r1 = ur_r_lj;
    for (int k = 0; k < nbits; k++) begin
      bclk = 1'b0;
      if (k == 0) daclrck = lr;
      #(HALF_BCLK);
      bclk = 1'b1;
      check($sformatf("i2s lr%0d bit%0d v=%h", lr, k, v), dacdat_i2s, exp_bit(1'b0, v, k));
      check($sformatf("lj lr%0d bit%0d v=%h", lr, k, v), dacdat_lj, exp_bit(1'b1, v, k));
      #(HALF_BCLK);
    end
    check_int("underrun_left_i2s pulses",  ur_l_i2s - l0, (edge_exp && !lr && uf) ? 1 : 0);
    check_int("underrun_right_i2s pulses", ur_r_i2s - r0, (edge_exp && lr && uf) ? 1 : 0);
    check_int("underrun_left_lj pulses",   ur_l_lj - l1,  (edge_exp && !lr && uf) ? 1 : 0);
    check_int("underrun_right_lj pulses",  ur_r_lj - r1,  (edge_exp && lr && uf) ? 1 : 0);
  endtask

  task automatic frame_pair();
    frame(1'b1, 32, 1'b1);
    frame(1'b0, 32, 1'b1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " dacdat_i2s"}, dacdat_i2s, 1'b0);
    check({tag, " dacdat_lj"}, dacdat_lj, 1'b0);
    check({tag, " left_ready_i2s"}, left_ready_i2s, 1'b0);
    check({tag, " right_ready_i2s"}, right_ready_i2s, 1'b0);
    check({tag, " left_ready_lj"}, left_ready_lj, 1'b0);
    check({tag, " right_ready_lj"}, right_ready_lj, 1'b0);
    check({tag, " underrun_left_i2s"}, underrun_left_i2s, 1'b0);
    check({tag, " underrun_right_lj"}, underrun_right_lj, 1'b0);
  endtask

  initial begin
    // Reset state and ready release
    repeat (3) @(negedge clk);
    check_reset_outputs("in_reset");
    reset_n = 1'b1;
    #1;
    check_reset_outputs("at_release");
    @(negedge clk);
    check_readys("after_release");

    // No pin activity: output stays quiet
    repeat (20) @(negedge clk);
    check("idle dacdat_i2s", dacdat_i2s, 1'b0);
    check("idle dacdat_lj", dacdat_lj, 1'b0);

    // Fill both FIFOs, then offer a fifth sample that must be held off
    push(1'b0, 24'h800001);
    push(1'b1, 24'h7FFFFE);
    for (int i = 0; i < 3; i++) begin
      push(1'b0, DW'($urandom));
      push(1'b1, DW'($urandom));
    end
    @(negedge clk);
    left_valid = 1'b1;
    right_valid = 1'b1;
    left_data = DW'($urandom);
    right_data = DW'($urandom);
    repeat (4) begin
      @(negedge clk);
      check_readys("full_hold");
    end
    left_valid = 1'b0;
    right_valid = 1'b0;

    // Drain with a mid-stream top-up
    frame_pair();
    frame_pair();
    push(1'b0, DW'($urandom));
    push(1'b1, DW'($urandom));
    frame_pair();
    frame_pair();
    frame_pair();

    // Left underrun while right has data
    push(1'b1, DW'($urandom));
    frame_pair();

    // Short right slot cut off by the next word-clock edge
    push(1'b0, DW'($urandom));
    push(1'b1, DW'($urandom));
    frame(1'b1, 20, 1'b1);
    frame(1'b0, 32, 1'b1);

    // Mute drains queued samples as zeros, then both channels underrun
    for (int i = 0; i < 2; i++) begin
      push(1'b0, DW'($urandom));
      push(1'b1, DW'($urandom));
    end
    mute = 1'b1;
    frame_pair();
    frame_pair();
    check_readys("mute_drained");
    frame_pair();
    mute = 1'b0;

    // Random traffic
    for (int p = 0; p < 4; p++) begin
      for (int i = 0; i < int'($urandom_range(0, 2)); i++) push(1'b0, DW'($urandom));
      for (int i = 0; i < int'($urandom_range(0, 2)); i++) push(1'b1, DW'($urandom));
      frame_pair();
    end
    while (q_l.size() > 0 || q_r.size() > 0) frame_pair();

    // Reset in the middle of a shifting left slot
    push(1'b0, 24'hFFFFFF);
    frame(1'b1, 32, 1'b1);
    frame(1'b0, 11, 1'b1);
    check("pre_reset dacdat_i2s", dacdat_i2s, 1'b1);
    check("pre_reset dacdat_lj", dacdat_lj, 1'b1);
    reset_n = 1'b0;
    #1;
    check_reset_outputs("mid_frame_reset");
    q_l.delete();
    q_r.delete();
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check_readys("after_rerelease");

    // Back in IDLE: BCLK alone must not start a slot
    push(1'b1, DW'($urandom));
    frame(1'b0, 32, 1'b0);
    frame(1'b1, 32, 1'b1);
    frame(1'b0, 32, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
